mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// No logic; enums and latency bounds only.
// No flow control of its own.
package cpu_mem_pkg;

  // Arbiter FSM: grant in IDLE, one memory cycle in ISSUE, read wait, completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Which requester owns the current transaction.
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  // Supported memory read latency range (cycles after the issue cycle).
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between fetch (req[0]) and data (req[1]).
// Combinational, zero latency.
// No backpressure; caller only uses grant when some req is set.
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_t       last,
  output gnt_t       grant
);

  // A lone requester wins outright; on a tie the port not served last wins.
  always_comb begin
    grant = last;
    if (req == 2'b11) begin
      grant = (last == GNT_IF) ? GNT_D : GNT_IF;
    end else if (req[1]) begin
      grant = GNT_D;
    end else if (req[0]) begin
      grant = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction fetch port and a data port.
// Latency: store completes 2 cycles after req is sampled, load/fetch 2+RD_LATENCY.
// Requesters hold req until their valid pulse; the loser simply waits in IDLE.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AWIDTH     = 16,
  parameter int WDWIDTH    = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [AWIDTH-1:0]  if_addr,
  output logic [WDWIDTH-1:0] if_rdata,
  output logic               if_valid,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [AWIDTH-1:0]  d_addr,
  input  logic [WDWIDTH-1:0] d_wdata,
  output logic [WDWIDTH-1:0] d_rdata,
  output logic               d_valid,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AWIDTH-1:0]  mem_addr,
  output logic [WDWIDTH-1:0] mem_wdata,
  input  logic [WDWIDTH-1:0] mem_rdata,
  output logic               busy
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  generate
    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
      $error("mem_port_arbiter: RD_LATENCY must be within 1..4");
    end
  endgenerate

  arb_state_t        state;
  arb_state_t        state_nxt;
  gnt_t              gnt;
  gnt_t              last_grant;
  gnt_t              arb_grant;
  logic              lat_we;
  logic [CNT_W-1:0]  lat_cnt;
  logic              grant_now;
  logic              rd_capture;

  rr_arb2 u_rr_arb2 (
    .req   ({d_req, if_req}),
    .last  (last_grant),
    .grant (arb_grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the state-decoded outputs (busy, completion pulses, capture strobe).
  always_comb begin
    state_nxt  = state;
    grant_now  = 1'b0;
    rd_capture = 1'b0;
    busy       = (state != IDLE);
    if_valid   = 1'b0;
    d_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant_now = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = lat_we ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_cnt == CNT_W'(RD_LATENCY)) begin
          rd_capture = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        if_valid  = (gnt == GNT_IF);
        d_valid   = (gnt == GNT_D);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and the registered memory command; en/we live only for the ISSUE cycle,
  // address/data hold between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= GNT_IF;
      last_grant <= GNT_IF;
      lat_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (grant_now) begin
        gnt        <= arb_grant;
        last_grant <= arb_grant;
        mem_en     <= 1'b1;
        mem_we     <= (arb_grant == GNT_D) && d_we;
        lat_we     <= (arb_grant == GNT_D) && d_we;
        mem_addr   <= (arb_grant == GNT_D) ? d_addr : if_addr;
        if (arb_grant == GNT_D) begin
          mem_wdata <= d_wdata;
        end
      end
    end
  end

  // Read latency counter: starts at 1 in the first WAIT cycle, data is present when it hits RD_LATENCY.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
    end else if (state == ISSUE && !lat_we) begin
      lat_cnt <= CNT_W'(1);
    end else if (state == WAIT) begin
      lat_cnt <= rd_capture ? '0 : lat_cnt + CNT_W'(1);
    end
  end

  // Per-port read data registers; each holds until its own port's next load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (rd_capture) begin
      if (gnt == GNT_IF) begin
        if_rdata <= mem_rdata;
      end else begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule
